// File: rtl/mac_result_collector.sv
// mac_result_collector: accumulates mac_array result beats over several
// input-channel passes, requantises Q4.28 -> Q2.14 and streams ofmap words.
module mac_result_collector #(
   parameter int NUM_MACS   = 16,
   parameter int RES_W      = 36,
   parameter int ACC_W      = 44,
   parameter int OUT_W      = 16,
   parameter int FRAC_SHIFT = 14,
   parameter int CH_W       = 7
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      start,
   input  logic [CH_W-1:0]           cfg_num_ch,
   input  logic                      cfg_mode,
   input  logic                      cfg_relu,
   input  logic                      in_valid,
   output logic                      in_ready,
   input  logic [NUM_MACS*RES_W-1:0] in_data,
   output logic                      out_valid,
   input  logic                      out_ready,
   output logic [OUT_W-1:0]          out_data,
   output logic [3:0]                out_idx,
   output logic                      out_last,
   output logic                      busy,
   output logic                      done
);

   localparam int SUM_W = RES_W + 4;
   localparam int EXT_W = ACC_W + 1;
   localparam logic [3:0] LAST_LANE = 4'(NUM_MACS - 1);
   localparam logic signed [EXT_W-1:0] RND =
      EXT_W'(1) << (FRAC_SHIFT - 1);

   typedef enum logic [1:0] {IDLE, ACCUM, DRAIN} state_t;

   state_t state_q, state_d;

   logic signed [ACC_W-1:0] acc_q [NUM_MACS];
   logic signed [ACC_W-1:0] acc_d [NUM_MACS];
   logic [CH_W-1:0]  pass_q, pass_d;
   logic [CH_W-1:0]  nch_q, nch_d;
   logic             mode_q, mode_d;
   logic             relu_q, relu_d;
   logic [3:0]       ld_idx_q, ld_idx_d;
   logic             all_ld_q, all_ld_d;
   logic             out_valid_q, out_valid_d;
   logic [OUT_W-1:0] out_data_q, out_data_d;
   logic [3:0]       out_idx_q, out_idx_d;
   logic             out_last_q, out_last_d;
   logic             done_q, done_d;

   logic signed [SUM_W-1:0] lane_sum;
   logic [CH_W:0]           target;
   logic                    final_beat;
   logic                    out_hs;
   logic [3:0]              last_lane;

   // Clamp a one-bit-wider sum back into the accumulator range.
   function automatic logic signed [ACC_W-1:0] sat_acc(
      input logic signed [EXT_W-1:0] x);
      logic signed [ACC_W-1:0] r;
      if (x[EXT_W-1] != x[EXT_W-2])
         r = x[EXT_W-1] ? {1'b1, {(ACC_W-1){1'b0}}}
                        : {1'b0, {(ACC_W-1){1'b1}}};
      else
         r = x[ACC_W-1:0];
      return r;
   endfunction

   function automatic logic signed [EXT_W-1:0] lane_ext(
      input logic [RES_W-1:0] l);
      return {{(EXT_W-RES_W){l[RES_W-1]}}, l};
   endfunction

   // Round half-up, optional ReLU, then saturate to Q2.14.
   function automatic logic [OUT_W-1:0] requant(
      input logic signed [ACC_W-1:0] a,
      input logic                    relu);
      logic signed [EXT_W-1:0] t;
      logic [EXT_W-OUT_W:0]    hi;
      logic [OUT_W-1:0]        r;
      t = {a[ACC_W-1], a} + RND;
      t = t >>> FRAC_SHIFT;
      if (relu && t[EXT_W-1])
         t = '0;
      hi = t[EXT_W-1:OUT_W-1];
      if ((&hi) || !(|hi))
         r = t[OUT_W-1:0];
      else if (t[EXT_W-1])
         r = {1'b1, {(OUT_W-1){1'b0}}};
      else
         r = {1'b0, {(OUT_W-1){1'b1}}};
      return r;
   endfunction

   // Cross-lane reduction used by the single-output mode.
   always_comb begin
      lane_sum = '0;
      for (int i = 0; i < NUM_MACS; i++)
         lane_sum = lane_sum +
            {{(SUM_W-RES_W){in_data[i*RES_W+RES_W-1]}},
             in_data[i*RES_W +: RES_W]};
   end

   assign target = (nch_q == '0) ? (CH_W+1)'(1) : {1'b0, nch_q};
   assign final_beat = ({1'b0, pass_q} + (CH_W+1)'(1)) == target;
   assign last_lane = mode_q ? 4'd0 : LAST_LANE;
   assign out_hs = out_valid_q && out_ready;

   // Next-state, accumulate and output-stage load logic.
   always_comb begin
      state_d     = state_q;
      pass_d      = pass_q;
      nch_d       = nch_q;
      mode_d      = mode_q;
      relu_d      = relu_q;
      acc_d       = acc_q;
      ld_idx_d    = ld_idx_q;
      all_ld_d    = all_ld_q;
      out_valid_d = out_valid_q;
      out_data_d  = out_data_q;
      out_idx_d   = out_idx_q;
      out_last_d  = out_last_q;
      done_d      = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (start) begin
               nch_d  = cfg_num_ch;
               mode_d = cfg_mode;
               relu_d = cfg_relu;
               pass_d = '0;
               for (int i = 0; i < NUM_MACS; i++)
                  acc_d[i] = '0;
               state_d = ACCUM;
            end
         end
         ACCUM: begin
            if (in_valid) begin
               if (mode_q) begin
                  acc_d[0] = sat_acc({acc_q[0][ACC_W-1], acc_q[0]} +
                     {{(EXT_W-SUM_W){lane_sum[SUM_W-1]}}, lane_sum});
               end else begin
                  for (int i = 0; i < NUM_MACS; i++)
                     acc_d[i] = sat_acc({acc_q[i][ACC_W-1], acc_q[i]} +
                        lane_ext(in_data[i*RES_W +: RES_W]));
               end
               pass_d = pass_q + CH_W'(1);
               if (final_beat) begin
                  state_d  = DRAIN;
                  ld_idx_d = '0;
                  all_ld_d = 1'b0;
               end
            end
         end
         DRAIN: begin
            if (out_hs && out_last_q) begin
               out_valid_d = 1'b0;
               done_d      = 1'b1;
               state_d     = IDLE;
            end else if ((!out_valid_q || out_ready) && !all_ld_q) begin
               out_valid_d = 1'b1;
               out_data_d  = requant(acc_q[ld_idx_q], relu_q);
               out_idx_d   = ld_idx_q;
               out_last_d  = (ld_idx_q == last_lane);
               all_ld_d    = (ld_idx_q == last_lane);
               ld_idx_d    = ld_idx_q + 4'd1;
            end else if (out_hs) begin
               out_valid_d = 1'b0;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // FSM state register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         state_q <= IDLE;
      else
         state_q <= state_d;
   end

   // Accumulators, job config and registered output stage.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NUM_MACS; i++)
            acc_q[i] <= '0;
         pass_q      <= '0;
         nch_q       <= '0;
         mode_q      <= 1'b0;
         relu_q      <= 1'b0;
         ld_idx_q    <= '0;
         all_ld_q    <= 1'b0;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         out_idx_q   <= '0;
         out_last_q  <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         acc_q       <= acc_d;
         pass_q      <= pass_d;
         nch_q       <= nch_d;
         mode_q      <= mode_d;
         relu_q      <= relu_d;
         ld_idx_q    <= ld_idx_d;
         all_ld_q    <= all_ld_d;
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
         out_idx_q   <= out_idx_d;
         out_last_q  <= out_last_d;
         done_q      <= done_d;
      end
   end

   assign in_ready  = (state_q == ACCUM);
   assign busy      = (state_q != IDLE);
   assign out_valid = out_valid_q;
   assign out_data  = out_data_q;
   assign out_idx   = out_idx_q;
   assign out_last  = out_last_q;
   assign done      = done_q;

endmodule
